// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the single-car elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    localparam int DEF_FLOORS      = 5;
    localparam int DEF_POS_W       = 3;
    localparam int DEF_DOOR_CYCLES = 3;

endpackage

// File: rtl/elevator_req_scan.sv
// Classifies the effective request mask relative to the car: at, above or below floor_pos.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = DEF_FLOORS,
    parameter int POS_W  = DEF_POS_W
) (
    input  logic [FLOORS-1:0] eff,
    input  logic [POS_W-1:0]  floor_pos,
    output logic              here,
    output logic              above,
    output logic              below
);

    always_comb begin
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (eff[i]) begin
                if (i == int'(floor_pos)) here  = 1'b1;
                if (i >  int'(floor_pos)) above = 1'b1;
                if (i <  int'(floor_pos)) below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator.sv
// Single-car LOOK elevator: pending request mask, car FSM, position counter and door timer.
//   state   | meaning
//   IDLE    | parked, no request ahead or behind
//   MOVE_UP | stepping up one floor per clock
//   MOVE_DN | stepping down one floor per clock
//   DOOR    | door open at floor_pos, timer counting down
module elevator
    import elevator_pkg::*;
#(
    parameter int FLOORS      = DEF_FLOORS,
    parameter int POS_W       = DEF_POS_W,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] floor_req,
    output logic [POS_W-1:0]  floor_pos,
    output logic              door_open,
    output logic              moving_up,
    output logic              moving_dn
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t             state, state_nxt;
    dir_t               dir, dir_nxt;
    logic [FLOORS-1:0]  pending, pending_nxt, eff;
    logic [POS_W-1:0]   pos_nxt;
    logic [CNT_W-1:0]   door_cnt, cnt_nxt;
    logic               here, above, below;
    logic               clear_here;
    state_t             resume_state;
    dir_t               resume_dir;

    assign eff = pending | floor_req;

    elevator_req_scan #(
        .FLOORS (FLOORS),
        .POS_W  (POS_W)
    ) u_scan (
        .eff       (eff),
        .floor_pos (floor_pos),
        .here      (here),
        .above     (above),
        .below     (below)
    );

    // LOOK choice shared by IDLE and door expiry: prefer the current direction.
    always_comb begin
        resume_state = IDLE;
        resume_dir   = dir;
        if (dir == UP) begin
            if (above) begin
                resume_state = MOVE_UP;
                resume_dir   = UP;
            end else if (below) begin
                resume_state = MOVE_DN;
                resume_dir   = DN;
            end
        end else begin
            if (below) begin
                resume_state = MOVE_DN;
                resume_dir   = DN;
            end else if (above) begin
                resume_state = MOVE_UP;
                resume_dir   = UP;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        pos_nxt    = floor_pos;
        cnt_nxt    = door_cnt;
        clear_here = 1'b0;
        case (state)
            IDLE: begin
                if (here) begin
                    state_nxt  = DOOR;
                    clear_here = 1'b1;
                    cnt_nxt    = CNT_LOAD;
                end else begin
                    state_nxt = resume_state;
                    dir_nxt   = resume_dir;
                end
            end
            MOVE_UP: begin
                if (here) begin
                    state_nxt  = DOOR;
                    clear_here = 1'b1;
                    cnt_nxt    = CNT_LOAD;
                end else if (above) begin
                    pos_nxt = floor_pos + 1'b1;
                end else if (below) begin
                    state_nxt = MOVE_DN;
                    dir_nxt   = DN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MOVE_DN: begin
                if (here) begin
                    state_nxt  = DOOR;
                    clear_here = 1'b1;
                    cnt_nxt    = CNT_LOAD;
                end else if (below) begin
                    pos_nxt = floor_pos - 1'b1;
                end else if (above) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = UP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOOR: begin
                // Requests for this floor are absorbed without extending the timer.
                clear_here = 1'b1;
                if (door_cnt == '0) begin
                    state_nxt = resume_state;
                    dir_nxt   = resume_dir;
                end else begin
                    cnt_nxt = door_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pending_nxt = eff;
        for (int i = 0; i < FLOORS; i++) begin
            if (clear_here && (i == int'(floor_pos))) pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= UP;
            floor_pos <= '0;
            pending   <= '0;
            door_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            floor_pos <= pos_nxt;
            pending   <= pending_nxt;
            door_cnt  <= cnt_nxt;
        end
    end

    assign door_open = (state == DOOR);
    assign moving_up = (state == MOVE_UP);
    assign moving_dn = (state == MOVE_DN);

endmodule

// File: tb/tb_elevator.sv
// Directed bench for the elevator controller: hand-computed per-edge position and output decode.
module tb_elevator;

    localparam int ST_I = 0;
    localparam int ST_U = 1;
    localparam int ST_D = 2;
    localparam int ST_O = 3;

    logic       clk;
    logic       reset;
    logic [4:0] floor_req;
    logic [2:0] floor_pos;
    logic       door_open;
    logic       moving_up;
    logic       moving_dn;

    int checks   = 0;
    int failures = 0;

    elevator dut (
        .clk       (clk),
        .reset     (reset),
        .floor_req (floor_req),
        .floor_pos (floor_pos),
        .door_open (door_open),
        .moving_up (moving_up),
        .moving_dn (moving_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int pos, input int code);
        logic [2:0] exp_o;
        case (code)
            ST_U:    exp_o = 3'b010;
            ST_D:    exp_o = 3'b001;
            ST_O:    exp_o = 3'b100;
            default: exp_o = 3'b000;
        endcase
        chk({tag, ".pos"}, 32'(floor_pos), 32'(pos));
        chk({tag, ".out"}, 32'({door_open, moving_up, moving_dn}), 32'(exp_o));
    endtask

    task automatic pulse(input logic [4:0] mask);
        floor_req = mask;
        tick();
        floor_req = '0;
    endtask

    initial begin
        reset     = 1'b0;
        floor_req = '0;
        repeat (3) tick();
        chk_st("rst_hold", 0, ST_I);
        reset = 1'b1;
        repeat (3) tick();
        chk_st("rst_quiet", 0, ST_I);

        // Single request to floor 3 from floor 0
        pulse(5'b01000); chk_st("single.e1", 0, ST_U);
        tick(); chk_st("single.e2", 1, ST_U);
        tick(); chk_st("single.e3", 2, ST_U);
        tick(); chk_st("single.e4", 3, ST_U);
        tick(); chk_st("single.e5", 3, ST_O);
        tick(); chk_st("single.e6", 3, ST_O);
        tick(); chk_st("single.e7", 3, ST_O);
        tick(); chk_st("single.e8", 3, ST_I);

        // Floors 1 and 4 from floor 3 heading up
        pulse(5'b10010); chk_st("multi.e1", 3, ST_U);
        tick(); chk_st("multi.e2", 4, ST_U);
        tick(); chk_st("multi.e3", 4, ST_O);
        tick(); chk_st("multi.e4", 4, ST_O);
        tick(); chk_st("multi.e5", 4, ST_O);
        tick(); chk_st("multi.e6", 4, ST_D);
        tick(); chk_st("multi.e7", 3, ST_D);
        tick(); chk_st("multi.e8", 2, ST_D);
        tick(); chk_st("multi.e9", 1, ST_D);
        tick(); chk_st("multi.e10", 1, ST_O);
        tick(); chk_st("multi.e11", 1, ST_O);
        tick(); chk_st("multi.e12", 1, ST_O);
        tick(); chk_st("multi.e13", 1, ST_I);
        repeat (3) tick();
        chk_st("multi.empty", 1, ST_I);

        // Floor 2, then floors 0 and 4 arrive while serving 2
        pulse(5'b00100); chk_st("dyn.e1", 1, ST_U);
        tick(); chk_st("dyn.e2", 2, ST_U);
        pulse(5'b10001); chk_st("dyn.e3", 2, ST_O);
        tick(); chk_st("dyn.e4", 2, ST_O);
        tick(); chk_st("dyn.e5", 2, ST_O);
        tick(); chk_st("dyn.e6", 2, ST_U);
        tick(); chk_st("dyn.e7", 3, ST_U);
        tick(); chk_st("dyn.e8", 4, ST_U);
        tick(); chk_st("dyn.e9", 4, ST_O);
        tick(); chk_st("dyn.e10", 4, ST_O);
        tick(); chk_st("dyn.e11", 4, ST_O);
        tick(); chk_st("dyn.e12", 4, ST_D);
        tick(); chk_st("dyn.e13", 3, ST_D);
        tick(); chk_st("dyn.e14", 2, ST_D);
        tick(); chk_st("dyn.e15", 1, ST_D);
        tick(); chk_st("dyn.e16", 0, ST_D);
        tick(); chk_st("dyn.e17", 0, ST_O);
        tick(); chk_st("dyn.e18", 0, ST_O);
        tick(); chk_st("dyn.e19", 0, ST_O);
        tick(); chk_st("dyn.e20", 0, ST_I);

        // Request for the current floor opens the door without moving
        pulse(5'b00001); chk_st("cur.e1", 0, ST_O);
        tick(); chk_st("cur.e2", 0, ST_O);
        tick(); chk_st("cur.e3", 0, ST_O);
        tick(); chk_st("cur.e4", 0, ST_I);

        // Floor 1 held for three edges gives a single stop
        floor_req = 5'b00010;
        tick(); chk_st("spam.e1", 0, ST_U);
        tick(); chk_st("spam.e2", 1, ST_U);
        tick(); chk_st("spam.e3", 1, ST_O);
        floor_req = '0;
        tick(); chk_st("spam.e4", 1, ST_O);
        tick(); chk_st("spam.e5", 1, ST_O);
        tick(); chk_st("spam.e6", 1, ST_I);
        repeat (4) tick();
        chk_st("spam.once", 1, ST_I);

        // Reset mid-move aborts immediately and drops the pending request
        pulse(5'b10000); chk_st("rmid.e1", 1, ST_U);
        tick(); chk_st("rmid.e2", 2, ST_U);
        reset = 1'b0;
        #1;
        chk_st("rmid.async", 0, ST_I);
        tick();
        #1;
        reset = 1'b1;
        repeat (6) tick();
        chk_st("rmid.lost", 0, ST_I);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
